// File: rtl/tok_pkg.sv
// Shared encodings for the keyword tokenizer: token codes, word FSM states, delimiter bytes.
// Purely declarative; no latency or backpressure of its own.
// Helpers are combinational and are used by the classifier in keyword_tokenizer.
package tok_pkg;

    typedef enum logic [1:0] {
        TOK_EOS   = 2'd0,
        TOK_BEGIN = 2'd1,
        TOK_END   = 2'd2,
        TOK_OTHER = 2'd3
    } tok_t;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_B1    = 4'd1,
        ST_B2    = 4'd2,
        ST_B3    = 4'd3,
        ST_B4    = 4'd4,
        ST_BFULL = 4'd5,
        ST_E1    = 4'd6,
        ST_E2    = 4'd7,
        ST_EFULL = 4'd8,
        ST_OTHER = 4'd9
    } word_st_t;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_TAB   = 8'h09;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;

    function automatic logic is_delim(input logic [7:0] c);
        return (c == CH_SPACE) || (c == CH_TAB) || (c == CH_LF) || (c == CH_CR);
    endfunction

    function automatic logic [7:0] to_lower(input logic [7:0] c);
        return ((c >= 8'h41) && (c <= 8'h5A)) ? (c + 8'h20) : c;
    endfunction

    // Only a fully matched keyword classifies; every other unfinished word is OTHER.
    function automatic tok_t word_tok(input word_st_t s);
        tok_t t;
        case (s)
            ST_BFULL: t = TOK_BEGIN;
            ST_EFULL: t = TOK_END;
            default:  t = TOK_OTHER;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/tok_fifo.sv
// Token FIFO: DEPTH x 2-bit, two write ports (slot 0 lands before slot 1), one read port.
// Latency: a write at edge N is visible on rd_vld/rd_dat after edge N; rd_dat is a register output.
// Backpressure: none internally; the writer must gate on count so that two slots are always free.
module tok_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr0_vld,
    input  logic [1:0]               wr0_dat,
    input  logic                     wr1_vld,
    input  logic [1:0]               wr1_dat,
    input  logic                     rd_rdy,
    output logic                     rd_vld,
    output logic [1:0]               rd_dat,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [1:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr_b;
    logic [CW-1:0] n_push;
    logic          pop;

    assign pop      = rd_rdy && (count != '0);
    assign n_push   = CW'(wr0_vld) + CW'(wr1_vld);
    // Second write packs directly behind the first so a lone wr1 still lands at wr_ptr.
    assign wr_ptr_b = wr_ptr + AW'(wr0_vld);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr0_vld) begin
                mem[wr_ptr] <= wr0_dat;
            end
            if (wr1_vld) begin
                mem[wr_ptr_b] <= wr1_dat;
            end
            wr_ptr <= wr_ptr + AW'(n_push);
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + n_push - CW'(pop);
        end
    end

    assign rd_vld = (count != '0);
    assign rd_dat = mem[rd_ptr];

endmodule

// File: rtl/keyword_tokenizer.sv
// Splits an ASCII stream into words and classifies each as BEGIN/END/OTHER (case-insensitive), plus EOS on in_last.
// Latency: token(s) for a character accepted at edge N appear on tok_valid/tok after edge N; no in->tok comb path.
// Backpressure: in_ready only while count <= FIFO_DEPTH-2; optional popped-token counter under TOK_COUNT_EN.
module keyword_tokenizer
    import tok_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in,
    input  logic        in_last,
    output logic        in_ready,
    output logic        tok_valid,
    output logic [1:0]  tok,
    input  logic        tok_ready
`ifdef TOK_COUNT_EN
    ,
    output logic [15:0] tok_count
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    word_st_t      state;
    word_st_t      state_nxt;
    word_st_t      char_st;
    word_st_t      word_st;
    logic [7:0]    lc;
    logic          delim;
    logic          accept;
    logic          word_push;
    logic          wr0_vld;
    logic [1:0]    wr0_dat;
    logic          wr1_vld;
    logic [1:0]    wr1_dat;
    logic [CW-1:0] fifo_count;

    // Two free slots cover the worst case of word token plus EOS from one character.
    assign in_ready = reset && (fifo_count <= CW'(FIFO_DEPTH - 2));
    assign accept   = in_valid && in_ready;
    assign lc       = to_lower(in);
    assign delim    = is_delim(in);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        char_st = ST_OTHER;
        case (state)
            ST_IDLE: begin
                if (lc == "b") begin
                    char_st = ST_B1;
                end else if (lc == "e") begin
                    char_st = ST_E1;
                end
            end
            ST_B1:   if (lc == "e") char_st = ST_B2;
            ST_B2:   if (lc == "g") char_st = ST_B3;
            ST_B3:   if (lc == "i") char_st = ST_B4;
            ST_B4:   if (lc == "n") char_st = ST_BFULL;
            ST_E1:   if (lc == "n") char_st = ST_E2;
            ST_E2:   if (lc == "d") char_st = ST_EFULL;
            default: char_st = ST_OTHER;
        endcase
    end

    always_comb begin
        state_nxt = state;
        word_st   = state;
        word_push = 1'b0;
        wr0_vld   = 1'b0;
        wr0_dat   = TOK_EOS;
        wr1_vld   = 1'b0;
        wr1_dat   = TOK_EOS;
        if (accept) begin
            if (delim) begin
                word_push = (state != ST_IDLE);
                word_st   = state;
                state_nxt = ST_IDLE;
            end else begin
                // A word character on in_last always leaves a non-IDLE word to close.
                word_push = in_last;
                word_st   = char_st;
                state_nxt = char_st;
            end
            if (in_last) begin
                state_nxt = ST_IDLE;
            end
            wr0_vld = word_push || in_last;
            wr0_dat = word_push ? word_tok(word_st) : TOK_EOS;
            wr1_vld = word_push && in_last;
            wr1_dat = TOK_EOS;
        end
    end

    tok_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr0_vld (wr0_vld),
        .wr0_dat (wr0_dat),
        .wr1_vld (wr1_vld),
        .wr1_dat (wr1_dat),
        .rd_rdy  (tok_ready),
        .rd_vld  (tok_valid),
        .rd_dat  (tok),
        .count   (fifo_count)
    );

`ifdef TOK_COUNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tok_count <= '0;
        end else if (tok_valid && tok_ready && (tok_count != 16'hFFFF)) begin
            tok_count <= tok_count + 16'd1;
        end
    end
`endif

endmodule

// File: doc/keyword_tokenizer.md
# keyword_tokenizer

Upstream stage of the block-nesting checker. Consumes a raw ASCII character stream with a valid/ready handshake, segments it into whitespace-delimited words and classifies each word case-insensitively as BEGIN, END or OTHER. Classified tokens are buffered in a small FIFO and offered downstream over a second valid/ready handshake. The checker therefore sees one token per word rather than one character per cycle.

## Interface
- FIFO_DEPTH, 4, token FIFO entries; power of two, ≥2
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- in_valid  in  1  character present on `in`
- in  in  8  ASCII character
- in_last  in  1  qualifies `in`: final character of the stream
- in_ready  out  1  character accepted when in_valid && in_ready
- tok_valid  out  1  FIFO head valid
- tok  out  2  head token: 0=EOS, 1=BEGIN, 2=END, 3=OTHER
- tok_ready  in  1  head popped when tok_valid && tok_ready

## Operation
- Delimiters: 0x20, 0x09, 0x0A, 0x0D. Any other byte is a word character. Letters are matched case-insensitively.
- Word FSM states: IDLE, B1, B2, B3, B4, BFULL, E1, E2, EFULL, OTHER.
- Transitions on an accepted word character:
  - IDLE: b→B1, e→E1, else OTHER
  - B1: e→B2; B2: g→B3; B3: i→B4; B4: n→BFULL
  - E1: n→E2; E2: d→EFULL
  - Any mismatch, and any character received in BFULL or EFULL, goes to OTHER. OTHER is absorbing until a delimiter.
- Accepted delimiter:
  - In IDLE: no token.
  - BFULL pushes BEGIN, EFULL pushes END, every other non-IDLE state pushes OTHER.
  - Next state is IDLE.
- in_last: the character is processed as above. If the FSM is still non-IDLE afterwards, the word is terminated as if a delimiter followed. EOS is then pushed after any word token. Next state is IDLE.
- A single accepted character can push 0, 1 or 2 tokens; word token order precedes EOS.
- in_ready = (count ≤ FIFO_DEPTH−2). Two free slots are always guaranteed, so no push is ever lost.
- Push and pop in the same cycle are legal; count changes by pushes − pop.
- tok_valid = (count ≠ 0). tok is the registered FIFO head. tok holds its value while tok_valid && !tok_ready.
- Pop while empty: ignored.
- Pointers wrap modulo FIFO_DEPTH. count is $clog2(FIFO_DEPTH)+1 bits wide.

## Timing
- Reset values: in_ready=1 (once reset releases), tok_valid=0, tok=0, FSM=IDLE, count=0, pointers=0.
- During reset assertion, in_ready=0.
- Latency: a character accepted at edge N makes its token(s) visible at tok_valid/tok after edge N (next cycle). There is no combinational path from in to tok.
- in_ready depends only on registered count. It does not depend on tok_ready in the same cycle.
- Reset mid-operation discards the partial word and all queued tokens immediately (asynchronous).
- A stalled downstream (tok_ready=0) fills the FIFO. in_ready drops once count reaches FIFO_DEPTH−1, and rises the cycle after a pop brings count back to FIFO_DEPTH−2.

## Configuration
- TOK_COUNT_EN defined: adds output `tok_count` (out, 16 bits). It counts tokens popped downstream, saturates at 0xFFFF, and resets to 0.
- TOK_COUNT_EN undefined: the port and counter are absent; behaviour is otherwise identical.

## Structure
- Shared package `tok_pkg` holds:
  - token encodings (TOK_EOS, TOK_BEGIN, TOK_END, TOK_OTHER)
  - word FSM state encodings
  - delimiter byte constants
- Sub-module `tok_fifo`: FIFO_DEPTH-entry, 2-bit-wide FIFO with a 2-write/1-read port and count output. The classifier FSM lives in the top module.

## Test plan
- Stream "BeGiN end" followed by ' ' with in_last, tok_ready=1 → tokens BEGIN, END, EOS, each visible one cycle after its terminating character.
- "beginx be endd" with in_last on the final 'd' → OTHER, OTHER, OTHER, EOS. The final two tokens are pushed in the same cycle, and count increments by 2.
- Tab, LF and repeated spaces between "end" and "begin" → exactly END, BEGIN; no OTHER for empty words.
- FIFO_DEPTH=4, tok_ready=0, feed "e " repeatedly → in_ready falls once count=3. Release tok_ready for one cycle → in_ready returns the next cycle, and no token is lost or duplicated.
- Drive reset low mid-word ("beg") while 2 tokens are queued → tok_valid=0 and count=0 immediately. Then "end " → only END.
- With TOK_COUNT_EN: pop 3 tokens → tok_count=3. Force near saturation → holds at 0xFFFF.
